spike_rate_encoder: RTL and testbench

Converts per-input intensity values into rate-coded spike trains that drive the `spike_in` vector of `if_network`, one timestep per clock. It is the transmitter side of the network's spike interface. Host logic loads one intensity per input channel, then starts a run of `num_steps` timesteps. Each channel emits spikes at a rate proportional to its intensity, using a deterministic phase accumulator.

---
 rtl/snn_enc_pkg.sv | 19 +
 rtl/spike_rate_encoder_if.sv | 31 +++
 rtl/spike_rate_channel.sv | 39 +++
 rtl/spike_rate_encoder.sv | 106 ++++++++++
 tb/tb_spike_rate_encoder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/snn_enc_pkg.sv
// Shared encoder types and width defaults, also used by the network tests.
package snn_enc_pkg;

    localparam int NUM_INPUTS_DEF  = 4;
    localparam int VALUE_WIDTH_DEF = 8;
    localparam int STEP_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    // Channel index width; a single channel still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Host-side control/status bundle of the spike rate encoder.
interface spike_rate_encoder_if #(
    parameter int NUM_INPUTS  = snn_enc_pkg::NUM_INPUTS_DEF,
    parameter int VALUE_WIDTH = snn_enc_pkg::VALUE_WIDTH_DEF,
    parameter int STEP_WIDTH  = snn_enc_pkg::STEP_WIDTH_DEF
);
    localparam int IDX_W = snn_enc_pkg::idx_width(NUM_INPUTS);

    logic                   load_valid;
    logic [IDX_W-1:0]       load_index;
    logic [VALUE_WIDTH-1:0] load_value;
    logic                   load_ready;
    logic                   start;
    logic [STEP_WIDTH-1:0]  num_steps;
    logic                   stop;
    logic                   busy;
    logic                   done;
    logic [STEP_WIDTH-1:0]  step_count;
    logic [NUM_INPUTS-1:0]  spike_out;

    modport master (
        output load_valid, load_index, load_value, start, num_steps, stop,
        input  load_ready, busy, done, step_count, spike_out
    );

    modport slave (
        input  load_valid, load_index, load_value, start, num_steps, stop,
        output load_ready, busy, done, step_count, spike_out
    );

endinterface

// File: rtl/spike_rate_channel.sv
// One rate-coded channel: intensity register, phase accumulator and the
// registered carry that becomes the spike.
module spike_rate_channel #(
    parameter int VALUE_WIDTH = snn_enc_pkg::VALUE_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [VALUE_WIDTH-1:0] load_value,
    input  logic                   clear,
    input  logic                   advance,
    output logic                   spike
);
    logic [VALUE_WIDTH-1:0] value;
    logic [VALUE_WIDTH-1:0] acc;
    logic [VALUE_WIDTH:0]   sum;

    // Carry out of the accumulator marks a spike.
    assign sum = {1'b0, acc} + {1'b0, value};

    // Value load, accumulator step and spike register; spike is forced low
    // whenever the channel is not advancing.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            acc   <= '0;
            spike <= 1'b0;
        end else begin
            if (load_en)
                value <= load_value;
            if (clear)
                acc <= '0;
            else if (advance)
                acc <= sum[VALUE_WIDTH-1:0];
            spike <= advance & sum[VALUE_WIDTH];
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-coded spike transmitter: FSM, timestep counter and load decode
// driving NUM_INPUTS phase-accumulator channels.
module spike_rate_encoder #(
    parameter int NUM_INPUTS  = snn_enc_pkg::NUM_INPUTS_DEF,
    parameter int VALUE_WIDTH = snn_enc_pkg::VALUE_WIDTH_DEF,
    parameter int STEP_WIDTH  = snn_enc_pkg::STEP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    spike_rate_encoder_if.slave  bus
);
    import snn_enc_pkg::*;

    localparam int IDX_W = idx_width(NUM_INPUTS);

    enc_state_t            state;
    logic [STEP_WIDTH-1:0] step_q;
    logic [STEP_WIDTH-1:0] n_lat;
    logic                  done_q;
    logic                  busy_q;
    logic                  ready_q;
    logic                  load_acc;
    logic                  clear;
    logic                  advance;
    logic                  last_step;
    logic [NUM_INPUTS-1:0] spk;

    // Channel controls; stop wins over advancing so the aborting edge emits nothing.
    assign load_acc  = (state == IDLE) && bus.load_valid;
    assign clear     = (state == IDLE) && bus.start;
    assign last_step = (step_q == n_lat);
    assign advance   = (state == RUN) && !bus.stop && !last_step;

    // Out-of-range indices match no channel and are dropped.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        spike_rate_channel #(.VALUE_WIDTH(VALUE_WIDTH)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .load_en    (load_acc && (bus.load_index == IDX_W'(i))),
            .load_value (bus.load_value),
            .clear      (clear),
            .advance    (advance),
            .spike      (spk[i])
        );
    end

    // Run-control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            step_q  <= '0;
            n_lat   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        step_q  <= '0;
                        n_lat   <= bus.num_steps;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        if (bus.num_steps == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (last_step) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.load_ready = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.step_count = step_q;
    assign bus.spike_out  = spk;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: closed-form rate model checked every cycle,
// directed scenarios with literal expectations, then randomized runs.
module tb_spike_rate_encoder;

    localparam int NI = 4;
    localparam int VW = 8;
    localparam int SW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spike_rate_encoder_if #(.NUM_INPUTS(NI), .VALUE_WIDTH(VW), .STEP_WIDTH(SW)) bus ();

    spike_rate_encoder #(.NUM_INPUTS(NI), .VALUE_WIDTH(VW), .STEP_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: phase 0 idle, 1 run, 2 done; m_k is the emitted step count.
    int m_vals [NI];
    int m_phase = 0;
    int m_k = 0;
    int m_n = 0;

    // Per-run observations.
    int cnt [NI];
    int first [NI];
    int done_c;
    int busys;
    logic [31:0] mask0;

    // Spikes of a channel up to step k are floor(k*v/2^VW); a spike at step k
    // is a change in that count.
    function automatic logic [NI-1:0] exp_spk(input int k);
        logic [NI-1:0] r;
        r = '0;
        for (int i = 0; i < NI; i++)
            r[i] = (k > 0) && (((k * m_vals[i]) >> VW) != (((k - 1) * m_vals[i]) >> VW));
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_k     <= 0;
            m_n     <= 0;
            for (int i = 0; i < NI; i++) m_vals[i] <= 0;
        end else begin
            case (m_phase)
                0: begin
                    if (bus.load_valid) m_vals[bus.load_index] <= int'(bus.load_value);
                    if (bus.start) begin
                        m_k     <= 0;
                        m_n     <= int'(bus.num_steps);
                        m_phase <= (bus.num_steps == 0) ? 2 : 1;
                    end
                end
                1: begin
                    if (bus.stop)        m_phase <= 0;
                    else if (m_k == m_n) m_phase <= 2;
                    else                 m_k <= m_k + 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Advance to the next falling edge and compare all outputs to the model.
    task automatic cyc();
        @(negedge clk);
        if (chk_en) begin
            check("spike_out", 64'(bus.spike_out), (m_phase == 1) ? 64'(exp_spk(m_k)) : 64'd0);
            check("done", 64'(bus.done), 64'(m_phase == 2));
            check("busy", 64'(bus.busy), 64'(m_phase != 0));
            check("load_ready", 64'(bus.load_ready), 64'(m_phase == 0));
            check("step_count", 64'(bus.step_count), 64'(m_k));
        end
    endtask

    task automatic do_load(input int idx, input int val);
        bus.load_valid = 1'b1;
        bus.load_index = 2'(idx);
        bus.load_value = 8'(val);
        cyc();
        bus.load_valid = 1'b0;
    endtask

    // Start a run of n steps and watch cycles 0..n+2; optional stop, in-run
    // load+start poke, or reset asserted during the given cycle.
    task automatic run(input int n, input int stop_at, input int poke_at, input int rst_at);
        for (int i = 0; i < NI; i++) begin cnt[i] = 0; first[i] = -1; end
        done_c = -1;
        busys  = 0;
        mask0  = '0;
        bus.start     = 1'b1;
        bus.num_steps = 16'(n);
        cyc();
        bus.start = 1'b0;
        for (int c = 0; c <= n + 2; c++) begin
            for (int i = 0; i < NI; i++)
                if (bus.spike_out[i] === 1'b1) begin
                    cnt[i]++;
                    if (first[i] < 0) first[i] = c;
                    if (i == 0 && c < 32) mask0[c] = 1'b1;
                end
            if (bus.done === 1'b1 && done_c < 0) done_c = c;
            if (bus.busy === 1'b1) busys++;
            bus.stop       = (c == stop_at);
            rst            = (c == rst_at);
            bus.load_valid = (c == poke_at);
            bus.start      = (c == poke_at);
            if (c == poke_at) begin
                bus.load_index = 2'd3;
                bus.load_value = 8'd200;
                bus.num_steps  = 16'd5;
            end
            cyc();
        end
        bus.stop = 1'b0; rst = 1'b0; bus.load_valid = 1'b0; bus.start = 1'b0;
    endtask

    initial begin
        int n, mode, sa, pa;
        bus.load_valid = 1'b0; bus.load_index = '0; bus.load_value = '0;
        bus.start = 1'b0; bus.num_steps = '0; bus.stop = 1'b0;
        rst = 1'b1;
        cyc(); cyc();
        check("rst_spike", 64'(bus.spike_out), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.load_ready), 64'd1);
        check("rst_step", 64'(bus.step_count), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc();

        // Half rate on channel 0.
        do_load(0, 128);
        run(8, -1, -1, -1);
        check("t1_cnt0", 64'(cnt[0]), 64'd4);
        check("t1_cnt1", 64'(cnt[1] + cnt[2] + cnt[3]), 64'd0);
        check("t1_mask0", 64'(mask0), 64'h154);
        check("t1_done", 64'(done_c), 64'd9);

        // Full range of rates over 256 steps.
        do_load(0, 255); do_load(1, 64); do_load(2, 1); do_load(3, 0);
        run(256, -1, -1, -1);
        check("t2_cnt0", 64'(cnt[0]), 64'd255);
        check("t2_cnt1", 64'(cnt[1]), 64'd64);
        check("t2_cnt2", 64'(cnt[2]), 64'd1);
        check("t2_cnt3", 64'(cnt[3]), 64'd0);
        check("t2_first2", 64'(first[2]), 64'd256);
        check("t2_done", 64'(done_c), 64'd257);

        // Zero-length run.
        run(0, -1, -1, -1);
        check("t3_done", 64'(done_c), 64'd0);
        check("t3_busy", 64'(busys), 64'd1);
        check("t3_spk", 64'(cnt[0] + cnt[1] + cnt[2]), 64'd0);

        // Abort in cycle 3, then a clean restart.
        do_load(0, 128);
        run(10, 3, -1, -1);
        check("t4_nodone", 64'(done_c), 64'hFFFF_FFFF_FFFF_FFFF);
        check("t4_step", 64'(bus.step_count), 64'd3);
        check("t4_cnt0", 64'(cnt[0]), 64'd1);
        run(10, -1, -1, -1);
        check("t4_first0", 64'(first[0]), 64'd2);
        check("t4_cnt0r", 64'(cnt[0]), 64'd5);

        // Load and start during a run are ignored; a later load takes effect.
        run(20, -1, 5, -1);
        check("t5_done", 64'(done_c), 64'd21);
        check("t5_cnt3", 64'(cnt[3]), 64'd0);
        do_load(3, 200);
        run(4, -1, -1, -1);
        check("t5_cnt3b", 64'(cnt[3]), 64'd3);

        // Reset mid-run clears everything including intensities.
        run(30, -1, -1, 5);
        check("t6_nodone", 64'(done_c), 64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_step", 64'(bus.step_count), 64'd0);
        run(16, -1, -1, -1);
        check("t6_cnt", 64'(cnt[0] + cnt[1] + cnt[2] + cnt[3]), 64'd0);

        // Randomized runs.
        for (int it = 0; it < 25; it++) begin
            int nl;
            nl = $urandom_range(0, 3);
            for (int j = 0; j < nl; j++)
                do_load($urandom_range(0, NI - 1), $urandom_range(0, 255));
            n    = $urandom_range(1, 40);
            mode = $urandom_range(0, 3);
            sa   = (mode == 0) ? $urandom_range(0, n - 1) : -1;
            pa   = (mode == 1) ? $urandom_range(0, n - 1) : -1;
            run(n, sa, pa, -1);
            if (mode != 0)
                for (int i = 0; i < NI; i++)
                    check("rand_cnt", 64'(cnt[i]), 64'((n * m_vals[i]) >> VW));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
